// File: rtl/hoop_pkg.sv
// Shared types, default constants and sizing helper for the hoop round controller.
package hoop_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      OVER = 2'd2
   } state_e;

   localparam int unsigned DEF_TICK_DIV        = 50000000;
   localparam int unsigned DEF_ROUND_SECS      = 10;
   localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;

   // Index/counter width for n states or items, never below one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/hoop_debounce.sv
// Single hoop channel: 2-FF synchroniser, stability counter, accepted level and
// combinational rising-edge strobe that coincides with the accepted level update.
module hoop_debounce
   import hoop_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic raw_i,
   output logic rise_c_o
);

   localparam int unsigned        CNT_W   = idx_w(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;

   // Counter only advances while the synchronised input disagrees with the accepted level.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (sync_q[1] != level_q) begin
         if (cnt_q == CNT_MAX) begin
            level_d = sync_q[1];
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   assign rise_c_o = level_d & ~level_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], raw_i};
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end

endmodule

// File: rtl/hoop_round_ctrl.sv
// Round controller: countdown timer, debounced per-hoop scoring and leader tracking.
// Define FINAL_BONUS_EN to score +2 per basket while time_left <= BONUS_SECS.
module hoop_round_ctrl
   import hoop_pkg::*;
#(
   parameter int unsigned TICK_DIV        = DEF_TICK_DIV,
   parameter int unsigned ROUND_SECS      = DEF_ROUND_SECS,
   parameter int unsigned NUM_HOOPS       = 2,
   parameter int unsigned SCORE_W         = 8,
   parameter int unsigned TIME_W          = 8,
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef FINAL_BONUS_EN
   ,
   parameter int unsigned BONUS_SECS      = 3
`endif
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           start,
   input  logic [NUM_HOOPS-1:0]           hoop_in,
   output logic [TIME_W-1:0]              time_left,
   output logic [NUM_HOOPS*SCORE_W-1:0]   score_flat,
   output logic                           running,
   output logic                           game_over,
   output logic                           round_done,
   output logic                           tick,
   output logic [SCORE_W-1:0]             best_score,
   output logic [idx_w(NUM_HOOPS)-1:0]    best_hoop
);

   localparam int unsigned        PRE_W   = idx_w(TICK_DIV);
   localparam int unsigned        IDX_W   = idx_w(NUM_HOOPS);
   localparam logic [PRE_W-1:0]   PRE_MAX = PRE_W'(TICK_DIV - 1);
   localparam logic [TIME_W-1:0]  ROUND_T = TIME_W'(ROUND_SECS);

   state_e                       state_q, state_d;
   logic [PRE_W-1:0]             pre_q, pre_d;
   logic [TIME_W-1:0]            time_q, time_d;
   logic [NUM_HOOPS*SCORE_W-1:0] score_q, score_d;
   logic                         tick_q, tick_d;
   logic                         done_q, done_d;
   logic                         run_q, over_q;
   logic                         clear_c;
   logic [SCORE_W-1:0]           best_q, best_d;
   logic [IDX_W-1:0]             best_idx_q, best_idx_d;
   logic [NUM_HOOPS-1:0]         rise_c;
   logic [SCORE_W-1:0]           inc_c;

   for (genvar g = 0; g < NUM_HOOPS; g++) begin : g_deb
      hoop_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_deb (
         .clk_i    (clock),
         .rst_i    (reset),
         .raw_i    (hoop_in[g]),
         .rise_c_o (rise_c[g])
      );
   end

`ifdef FINAL_BONUS_EN
   assign inc_c = (time_q <= TIME_W'(BONUS_SECS)) ? SCORE_W'(2) : SCORE_W'(1);
`else
   assign inc_c = SCORE_W'(1);
`endif

   function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                  input logic [SCORE_W-1:0] b);
      logic [SCORE_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
   endfunction

   // Round FSM, prescaler/timer and scoring.
   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      time_d  = time_q;
      score_d = score_q;
      tick_d  = 1'b0;
      done_d  = 1'b0;
      clear_c = 1'b0;
      unique case (state_q)
         IDLE, OVER: begin
            if (start) begin
               state_d = RUN;
               pre_d   = '0;
               time_d  = ROUND_T;
               score_d = '0;
               clear_c = 1'b1;
            end
         end
         RUN: begin
            if (pre_q == PRE_MAX) begin
               pre_d  = '0;
               tick_d = 1'b1;
               time_d = time_q - TIME_W'(1);
               if (time_q == TIME_W'(1)) begin
                  state_d = OVER;
                  done_d  = 1'b1;
               end
            end else begin
               pre_d = pre_q + PRE_W'(1);
            end
            for (int i = 0; i < NUM_HOOPS; i++) begin
               if (rise_c[i]) begin
                  score_d[i*SCORE_W +: SCORE_W] = sat_add(score_q[i*SCORE_W +: SCORE_W], inc_c);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Leader over the registered scores; strict compare keeps the lowest index on ties.
   always_comb begin
      best_d     = '0;
      best_idx_d = '0;
      for (int i = 0; i < NUM_HOOPS; i++) begin
         if (score_q[i*SCORE_W +: SCORE_W] > best_d) begin
            best_d     = score_q[i*SCORE_W +: SCORE_W];
            best_idx_d = IDX_W'(i);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         pre_q      <= '0;
         time_q     <= ROUND_T;
         score_q    <= '0;
         tick_q     <= 1'b0;
         done_q     <= 1'b0;
         run_q      <= 1'b0;
         over_q     <= 1'b0;
         best_q     <= '0;
         best_idx_q <= '0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         time_q  <= time_d;
         score_q <= score_d;
         tick_q  <= tick_d;
         done_q  <= done_d;
         run_q   <= (state_d == RUN);
         over_q  <= (state_d == OVER);
         if (clear_c) begin
            best_q     <= '0;
            best_idx_q <= '0;
         end else begin
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
         end
      end
   end

   assign time_left  = time_q;
   assign score_flat = score_q;
   assign running    = run_q;
   assign game_over  = over_q;
   assign round_done = done_q;
   assign tick       = tick_q;
   assign best_score = best_q;
   assign best_hoop  = best_idx_q;

endmodule

// File: tb/tb_hoop_round_ctrl.sv
// Scoreboard bench for hoop_round_ctrl: short-round instance A and long-round instance B.
module tb_hoop_round_ctrl;

   localparam int DEB = 2;
`ifdef FINAL_BONUS_EN
   localparam int EXP_BONUS = 3;
`else
   localparam int EXP_BONUS = 2;
`endif

   typedef struct {
      int    dut;
      int    hoop;
      int    score;
      longint due;
   } sb_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       start_a, start_b;
   logic [1:0] hoop_a, hoop_b;

   logic [7:0] time_left_a, time_left_b, score_a, score_b;
   logic       running_a, running_b, game_over_a, game_over_b;
   logic       round_done_a, round_done_b, tick_a, tick_b;
   logic [3:0] best_score_a, best_score_b;
   logic [0:0] best_hoop_a, best_hoop_b;

   int     n_checks = 0;
   int     n_pass   = 0;
   longint cyc      = 0;
   int     rd_a     = 0;
   int     rd_b     = 0;
   logic [7:0] prev_score [2];
   sb_t    sbq [$];

   always #5 clk = ~clk;

   hoop_round_ctrl #(
      .TICK_DIV(4), .ROUND_SECS(3), .NUM_HOOPS(2), .SCORE_W(4), .TIME_W(8), .DEBOUNCE_CYCLES(DEB)
`ifdef FINAL_BONUS_EN
      , .BONUS_SECS(1)
`endif
   ) u_dut_a (
      .clock(clk), .reset(reset), .start(start_a), .hoop_in(hoop_a),
      .time_left(time_left_a), .score_flat(score_a), .running(running_a),
      .game_over(game_over_a), .round_done(round_done_a), .tick(tick_a),
      .best_score(best_score_a), .best_hoop(best_hoop_a)
   );

   hoop_round_ctrl #(
      .TICK_DIV(64), .ROUND_SECS(15), .NUM_HOOPS(2), .SCORE_W(4), .TIME_W(8), .DEBOUNCE_CYCLES(DEB)
`ifdef FINAL_BONUS_EN
      , .BONUS_SECS(1)
`endif
   ) u_dut_b (
      .clock(clk), .reset(reset), .start(start_b), .hoop_in(hoop_b),
      .time_left(time_left_b), .score_flat(score_b), .running(running_b),
      .game_over(game_over_b), .round_done(round_done_b), .tick(tick_b),
      .best_score(best_score_b), .best_hoop(best_hoop_b)
   );

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
   endtask

   // Pop one scoreboard entry for every score increase seen on either instance.
   task automatic monitor();
      logic [7:0] f;
      logic [3:0] cur, old;
      sb_t        e;
      for (int d = 0; d < 2; d++) begin
         f = (d == 0) ? score_a : score_b;
         for (int h = 0; h < 2; h++) begin
            cur = f[h*4 +: 4];
            old = prev_score[d][h*4 +: 4];
            if (cur > old) begin
               if (sbq.size() == 0) begin
                  check("sb_unexpected", longint'(cur), longint'(old));
               end else begin
                  e = sbq.pop_front();
                  check("sb_dut", d, e.dut);
                  check("sb_hoop", h, e.hoop);
                  check("sb_score", longint'(cur), e.score);
                  check("sb_latency", cyc, e.due);
               end
            end
         end
         prev_score[d] = f;
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         cyc++;
         rd_a += int'(round_done_a);
         rd_b += int'(round_done_b);
         monitor();
      end
   endtask

   task automatic set_hoop(input int dut, input int h, input logic v);
      if (dut == 0) hoop_a[h] = v;
      else          hoop_b[h] = v;
   endtask

   task automatic pulse_start(input int dut);
      if (dut == 0) start_a = 1'b1;
      else          start_b = 1'b1;
      step(1);
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic pulse(input int dut, input int h, input int hold, input int gap,
                        input bit exp_inc, input int exp_score);
      if (exp_inc) sbq.push_back('{dut, h, exp_score, cyc + longint'(DEB + 2)});
      set_hoop(dut, h, 1'b1);
      step(hold);
      set_hoop(dut, h, 1'b0);
      step(gap);
   endtask

   initial begin
      prev_score[0] = '0;
      prev_score[1] = '0;
      reset   = 1'b1;
      start_a = 1'b0;
      start_b = 1'b0;
      hoop_a  = '0;
      hoop_b  = '0;
      step(3);
      reset = 1'b0;

      // Reset state
      check("rst_flags", {running_a, game_over_a, round_done_a, tick_a}, 0);
      check("rst_time", time_left_a, 3);
      check("rst_score", score_a, 0);
      check("rst_best", {best_score_a, best_hoop_a}, 0);
      check("rst_time_b", time_left_b, 15);

      // Full countdown on A
      rd_a = 0;
      pulse_start(0);
      check("t1_running", running_a, 1);
      check("t1_time0", time_left_a, 3);
      for (int i = 1; i <= 12; i++) begin
         step(1);
         check("t1_tick", tick_a, (i % 4 == 0) ? 1 : 0);
         check("t1_time", time_left_a, 3 - i / 4);
         check("t1_running", running_a, (i < 12) ? 1 : 0);
         check("t1_over", game_over_a, (i == 12) ? 1 : 0);
         check("t1_done", round_done_a, (i == 12) ? 1 : 0);
      end
      step(1);
      check("t1_done_once", rd_a, 1);
      check("t1_over_hold", game_over_a, 1);
      check("t1_score", score_a, 0);

      // Clean pulse in OVER, then bounce during RUN: no score
      pulse(0, 1, 4, 6, 1'b0, 0);
      check("t3_over_pulse", score_a, 0);
      pulse_start(0);
      for (int i = 0; i < 10; i++) begin
         hoop_a[1] = (i % 2 == 0);
         step(1);
      end
      hoop_a[1] = 1'b0;
      step(2);
      check("t3_bounce_score", score_a, 0);
      check("t3_best", best_score_a, 0);
      check("t3_ended", game_over_a, 1);

      // Restart, ignored start in RUN, mid-round reset
      pulse_start(0);
      hoop_a[0] = 1'b1;
      sbq.push_back('{0, 0, 1, cyc + longint'(DEB + 2)});
      step(2);
      start_a = 1'b1;
      step(1);
      start_a = 1'b0;
      step(1);
      hoop_a[0] = 1'b0;
      step(2);
      check("t5_time_mid", time_left_a, 2);
      check("t5_score_mid", score_a, 8'h01);
      check("t5_best_mid", {best_score_a, best_hoop_a}, {4'd1, 1'b0});
      rd_a  = 0;
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      check("t5_rst_flags", {running_a, game_over_a, round_done_a}, 0);
      check("t5_rst_time", time_left_a, 3);
      check("t5_rst_score", score_a, 0);
      check("t5_rst_best", best_score_a, 0);
      pulse(0, 1, 4, 6, 1'b0, 0);
      check("t5_idle_score", score_a, 0);
      check("t5_no_done", rd_a, 0);

      pulse_start(0);
      hoop_a[0] = 1'b1;
      sbq.push_back('{0, 0, 1, cyc + longint'(DEB + 2)});
      step(4);
      hoop_a[0] = 1'b0;
      step(8);
      check("t5_over", game_over_a, 1);
      check("t5_over_time", time_left_a, 0);
      check("t5_over_best", best_score_a, 1);
      step(3);
      check("t5_over_hold", score_a, 8'h01);
      rd_a = 0;
      pulse_start(0);
      check("t5_restart_score", score_a, 0);
      check("t5_restart_time", time_left_a, 3);
      check("t5_restart_flags", {running_a, game_over_a}, 2'b10);
      step(1);
      check("t5_restart_nodone", rd_a, 0);

      // Multi-hoop scoring, saturation and tie on B
      pulse_start(1);
      for (int k = 1; k <= 3; k++) pulse(1, 0, 6, 6, 1'b1, k);
      pulse(1, 1, 6, 6, 1'b1, 1);
      step(2);
      check("t2_scores", score_b, 8'h13);
      check("t2_best", {best_score_b, best_hoop_b}, {4'd3, 1'b0});
      for (int k = 1; k <= 20; k++) pulse(1, 0, 4, 4, (3 + k <= 15), 3 + k);
      check("t4_sat", score_b[3:0], 15);
      check("t4_best", best_score_b, 15);
      for (int k = 2; k <= 15; k++) pulse(1, 1, 4, 4, 1'b1, k);
      step(2);
      check("t4_tie_scores", score_b, 8'hFF);
      check("t4_tie_hoop", best_hoop_b, 0);

      rd_b = 0;
      for (int i = 0; i < 1500 && !game_over_b; i++) step(1);
      step(2);
      check("t4_end", game_over_b, 1);
      check("t4_done_once", rd_b, 1);
      check("t4_end_time", time_left_b, 0);

      // Final-window scoring on B
      pulse_start(1);
      check("t6_clear", score_b, 0);
      check("t6_best_clear", best_score_b, 0);
      for (int i = 0; i < 1000 && time_left_b != 8'd2; i++) step(1);
      check("t6_reach2", time_left_b, 2);
      pulse(1, 1, 4, 4, 1'b1, 1);
      for (int i = 0; i < 200 && time_left_b != 8'd1; i++) step(1);
      check("t6_reach1", time_left_b, 1);
      pulse(1, 1, 4, 4, 1'b1, EXP_BONUS);
      step(2);
      check("t6_score", score_b[7:4], EXP_BONUS);
      check("t6_best", {best_score_b, best_hoop_b}, {4'(EXP_BONUS), 1'b1});

      check("sb_drain", sbq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
